// File: rtl/pixel_packer_pkg.sv
// Shared constants and types for the pixel packer: frame geometry, field
// widths and the byte handshake state encoding.
package pixel_packer_pkg;

  localparam int WIDTH       = 400;
  localparam int HEIGHT      = 300;
  localparam int NUM_PIXELS  = WIDTH * HEIGHT;
  localparam int PIX_WIDTH   = 4;
  localparam int BYTE_WIDTH  = 2 * PIX_WIDTH;
  localparam int COUNT_WIDTH = 17;

  // Four-phase handshake toward the RP2040.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_t;

  // First nibble of a pair lands in the low half, second in the high half.
  function automatic logic [BYTE_WIDTH-1:0] pack_pair(
    input logic [PIX_WIDTH-1:0] first_nib,
    input logic [PIX_WIDTH-1:0] second_nib
  );
    return {second_nib, first_nib};
  endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel stream in, packed byte handshake out, plus frame status.
// master: the packer side; slave: the engine / RP2040 side.
interface pixel_packer_if;
  import pixel_packer_pkg::*;

  logic                   frame_start;
  logic [PIX_WIDTH-1:0]   pix_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [BYTE_WIDTH-1:0]  byte_data;
  logic                   byte_req;
  logic                   byte_ack;
  logic [COUNT_WIDTH-1:0] pix_count;
  logic                   frame_done;

  modport master (
    input  frame_start, pix_data, pix_valid, byte_ack,
    output pix_ready, byte_data, byte_req, pix_count, frame_done
  );

  modport slave (
    output frame_start, pix_data, pix_valid, byte_ack,
    input  pix_ready, byte_data, byte_req, pix_count, frame_done
  );

endinterface

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a synchronous
// clear. Pointers wrap naturally because DEPTH is a power of two.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would otherwise infer a latch.
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // Pointers, occupancy and the registered flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array written on push.
  always_ff @(posedge clk) begin
    // NOTE: the storage is deliberately not reset; the pointers and flags
    // already mark every entry invalid, and unreset arrays map to RAM.
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs pairs of 4-bit pixels into bytes, buffers them in a small FIFO and
// hands each byte to the RP2040 over a four-phase req/ack handshake.
module pixel_packer #(
  parameter int NUM_PIXELS = pixel_packer_pkg::NUM_PIXELS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pixel_packer_if.master bus
);
  import pixel_packer_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] PIX_MAX   = COUNT_WIDTH'(NUM_PIXELS);
  localparam bit                     ODD_FRAME = (NUM_PIXELS % 2) == 1;

  // Synchronizer for the asynchronous acknowledge.
  logic ack_meta;
  logic ack_s;

  // Packing state.
  logic                   phase;
  logic [PIX_WIDTH-1:0]   low_nib;
  logic [COUNT_WIDTH-1:0] pix_count;
  logic                   pix_ready;
  logic                   accept;
  logic                   frame_full;
  logic                   pair_push;
  logic                   tail_push;

  // FIFO connections.
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [BYTE_WIDTH-1:0] fifo_wdata;
  logic [BYTE_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Handshake FSM state and registered outputs.
  hs_state_t             state;
  logic                  byte_req;
  logic [BYTE_WIDTH-1:0] byte_data;
  logic                  frame_done;

  // Ready is withheld when the second nibble would hit a full FIFO; the
  // flag is registered, so a pop in the same cycle does not help.
  assign frame_full = (pix_count == PIX_MAX);
  assign pix_ready  = !rst && !(phase && fifo_full) && (pix_count < PIX_MAX)
                      && !bus.frame_start;
  assign accept     = bus.pix_valid && pix_ready;

  // A pair completes on the second accepted nibble; a lone final nibble of
  // an odd frame is flushed as soon as there is room.
  assign pair_push  = accept && phase;
  assign tail_push  = ODD_FRAME && phase && frame_full && !fifo_full
                      && !bus.frame_start;
  assign fifo_push  = pair_push || tail_push;
  assign fifo_wdata = pair_push ? pack_pair(low_nib, bus.pix_data)
                                : pack_pair(low_nib, {PIX_WIDTH{1'b0}});
  assign fifo_pop   = (state == REQ) && ack_s && !bus.frame_start;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.frame_start),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Two-flop synchronizer on byte_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus.byte_ack;
      ack_s    <= ack_meta;
    end
  end

  // Nibble pairing and the saturating per-frame pixel counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      low_nib   <= '0;
      pix_count <= '0;
    end else if (bus.frame_start) begin
      phase     <= 1'b0;
      pix_count <= '0;
    end else if (accept) begin
      pix_count <= pix_count + 1'b1;
      phase     <= !phase;
      if (!phase) low_nib <= bus.pix_data;
    end else if (tail_push) begin
      phase <= 1'b0;
    end
  end

  // Four-phase handshake FSM; a restart abandons the in-flight byte but
  // still waits for the acknowledge to return low before the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_req   <= 1'b0;
      byte_data  <= '0;
      frame_done <= 1'b0;
    end else if (bus.frame_start) begin
      frame_done <= 1'b0;
      byte_req   <= 1'b0;
      if (state == REQ) state <= WAIT_LOW;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            byte_data <= fifo_rdata;
            byte_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            byte_req <= 1'b0;
            state    <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            state <= IDLE;
            if (frame_full && fifo_empty && !phase) frame_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          byte_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.byte_data  = byte_data;
  assign bus.byte_req   = byte_req;
  assign bus.pix_count  = pix_count;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: three instances (default frame, 6-pixel
// frame, 5-pixel frame) share one stimulus; 'sel' picks the observed one.
module tb_pixel_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       byte_ack = 1'b0;
  logic [3:0] pix_data = 4'h0;

  always #5 clk = ~clk;

  pixel_packer_if ifa ();
  pixel_packer_if if6 ();
  pixel_packer_if if5 ();

  assign ifa.frame_start = frame_start;
  assign ifa.pix_data    = pix_data;
  assign ifa.pix_valid   = pix_valid;
  assign ifa.byte_ack    = byte_ack;
  assign if6.frame_start = frame_start;
  assign if6.pix_data    = pix_data;
  assign if6.pix_valid   = pix_valid;
  assign if6.byte_ack    = byte_ack;
  assign if5.frame_start = frame_start;
  assign if5.pix_data    = pix_data;
  assign if5.pix_valid   = pix_valid;
  assign if5.byte_ack    = byte_ack;

  pixel_packer #(.NUM_PIXELS(120000), .FIFO_DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pixel_packer #(.NUM_PIXELS(6),      .FIFO_DEPTH(4)) dut_6 (.clk(clk), .rst(rst), .bus(if6));
  pixel_packer #(.NUM_PIXELS(5),      .FIFO_DEPTH(4)) dut_5 (.clk(clk), .rst(rst), .bus(if5));

  int          sel = 0;
  logic        obs_ready;
  logic        obs_req;
  logic        obs_done;
  logic [7:0]  obs_data;
  logic [16:0] obs_count;

  always_comb begin
    case (sel)
      6: begin
        obs_ready = if6.pix_ready; obs_req = if6.byte_req; obs_done = if6.frame_done;
        obs_data  = if6.byte_data; obs_count = if6.pix_count;
      end
      5: begin
        obs_ready = if5.pix_ready; obs_req = if5.byte_req; obs_done = if5.frame_done;
        obs_data  = if5.byte_data; obs_count = if5.pix_count;
      end
      default: begin
        obs_ready = ifa.pix_ready; obs_req = ifa.byte_req; obs_done = ifa.frame_done;
        obs_data  = ifa.byte_data; obs_count = ifa.pix_count;
      end
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock; a pixel offered to the observed DUT and accepted is withdrawn.
  task automatic step();
    logic acc;
    @(negedge clk);
    acc = pix_valid && obs_ready;
    @(posedge clk);
    #1;
    if (acc) pix_valid = 1'b0;
  endtask

  task automatic feed(input logic [3:0] value);
    pix_data  = value;
    pix_valid = 1'b1;
    for (int i = 0; i < 50 && pix_valid; i++) step();
    if (pix_valid) begin
      check("feed_timeout", {31'd0, pix_valid}, 32'd0);
      pix_valid = 1'b0;
    end
  endtask

  task automatic wait_req(input logic level);
    for (int i = 0; i < 40 && obs_req !== level; i++) step();
    check("req_wait", {31'd0, obs_req}, {31'd0, level});
  endtask

  task automatic handshake(input string tag, input logic [7:0] expected);
    wait_req(1'b1);
    check(tag, {24'd0, obs_data}, {24'd0, expected});
    byte_ack = 1'b1;
    wait_req(1'b0);
    byte_ack = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && obs_done !== 1'b1; i++) step();
    check("frame_done", {31'd0, obs_done}, 32'd1);
  endtask

  task automatic restart_frame();
    rst = 1'b1;
    step();
    rst = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset values.
    sel = 0;
    step();
    step();
    check("rst_req",   {31'd0, ifa.byte_req},   32'd0);
    check("rst_data",  {24'd0, ifa.byte_data},  32'd0);
    check("rst_count", {15'd0, ifa.pix_count},  32'd0);
    check("rst_done",  {31'd0, ifa.frame_done}, 32'd0);
    check("rst_ready", {31'd0, ifa.pix_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, ifa.pix_ready}, 32'd1);
    frame_start = 1'b1;
    #1;
    check("ready_in_frame_start", {31'd0, ifa.pix_ready}, 32'd0);
    step();
    frame_start = 1'b0;

    // Pair packing: 0x3 then 0xA -> 0xA3, request held until ack_s.
    feed(4'h3);
    feed(4'hA);
    check("pair_count", {15'd0, ifa.pix_count}, 32'd2);
    wait_req(1'b1);
    check("pair_data", {24'd0, ifa.byte_data}, 32'hA3);
    repeat (3) begin
      step();
      check("pair_req_hold", {31'd0, ifa.byte_req}, 32'd1);
    end
    byte_ack = 1'b1;
    step();
    check("pair_req_sync1", {31'd0, ifa.byte_req}, 32'd1);
    step();
    check("pair_req_sync2", {31'd0, ifa.byte_req}, 32'd1);
    step();
    check("pair_req_drop", {31'd0, ifa.byte_req}, 32'd0);
    byte_ack = 1'b0;
    repeat (4) step();

    // Backpressure: four bytes fill the FIFO, the 9th pixel still fits.
    restart_frame();
    for (int v = 1; v <= 9; v++) feed(4'(v));
    pix_data  = 4'hA;
    pix_valid = 1'b1;
    repeat (3) step();
    check("bp_ready",   {31'd0, ifa.pix_ready}, 32'd0);
    check("bp_count",   {15'd0, ifa.pix_count}, 32'd9);
    check("bp_pending", {31'd0, pix_valid},     32'd1);
    handshake("bp_byte0", 8'h21);
    handshake("bp_byte1", 8'h43);
    handshake("bp_byte2", 8'h65);
    handshake("bp_byte3", 8'h87);
    handshake("bp_byte4", 8'hA9);
    check("bp_count_final", {15'd0, ifa.pix_count}, 32'd10);
    repeat (4) step();

    // Frame end on a 6-pixel frame.
    sel = 6;
    restart_frame();
    for (int v = 1; v <= 6; v++) feed(4'(v));
    handshake("fe_byte0", 8'h21);
    handshake("fe_byte1", 8'h43);
    check("fe_done_early", {31'd0, if6.frame_done}, 32'd0);
    handshake("fe_byte2", 8'h65);
    wait_done();
    check("fe_ready", {31'd0, if6.pix_ready}, 32'd0);
    check("fe_count", {15'd0, if6.pix_count}, 32'd6);
    pix_data  = 4'h7;
    pix_valid = 1'b1;
    repeat (3) step();
    check("fe_7th_rejected", {31'd0, pix_valid}, 32'd1);
    check("fe_count_hold",   {15'd0, if6.pix_count}, 32'd6);
    pix_valid = 1'b0;
    repeat (2) step();

    // Reset priority: the default-frame instance is mid-request, the
    // 6-pixel instance is done; rst and frame_start together.
    sel = 0;
    check("rp_pre_req",  {31'd0, ifa.byte_req},   32'd1);
    check("rp_pre_data", {24'd0, ifa.byte_data},  32'h77);
    check("rp_pre_done", {31'd0, if6.frame_done}, 32'd1);
    rst = 1'b1;
    frame_start = 1'b1;
    step();
    check("rp_req",   {31'd0, ifa.byte_req},   32'd0);
    check("rp_data",  {24'd0, ifa.byte_data},  32'd0);
    check("rp_count", {15'd0, ifa.pix_count},  32'd0);
    check("rp_done",  {31'd0, if6.frame_done}, 32'd0);
    check("rp_ready", {31'd0, ifa.pix_ready},  32'd0);
    rst = 1'b0;
    frame_start = 1'b0;
    #1;
    check("rp_ready_after", {31'd0, ifa.pix_ready}, 32'd1);
    step();

    // Odd frame: lone 5th nibble flushed with a zero upper half.
    sel = 5;
    restart_frame();
    for (int v = 1; v <= 5; v++) feed(4'(v));
    handshake("odd_byte0", 8'h21);
    handshake("odd_byte1", 8'h43);
    handshake("odd_byte2", 8'h05);
    wait_done();
    check("odd_count", {15'd0, if5.pix_count}, 32'd5);
    repeat (2) step();

    // Restart while byte_req is high.
    sel = 0;
    restart_frame();
    feed(4'h3);
    feed(4'hA);
    wait_req(1'b1);
    byte_ack = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("mr_req",   {31'd0, ifa.byte_req},       32'd0);
    check("mr_count", {15'd0, ifa.pix_count},      32'd0);
    check("mr_empty", {31'd0, dut_a.u_fifo.empty}, 32'd1);
    feed(4'h5);
    feed(4'h6);
    repeat (4) begin
      step();
      check("mr_req_wait", {31'd0, ifa.byte_req}, 32'd0);
    end
    byte_ack = 1'b0;
    handshake("mr_new_byte", 8'h65);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
